// File: rtl/pio_debounce_irq.sv
// Avalon-MM PIO: synchronised, debounced inputs with edge capture and
// maskable level IRQ; output register with atomic set/clear aliases.
module pio_debounce_irq #(
  parameter int                     IN_WIDTH        = 8,
  parameter int                     OUT_WIDTH       = 8,
  parameter int                     SYNC_STAGES     = 2,
  parameter int                     DEBOUNCE_CYCLES = 50000,
  parameter int                     EDGE_TYPE       = 0,
  parameter logic [OUT_WIDTH-1:0]   RESET_OUT       = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [2:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 irq,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [IN_WIDTH-1:0]  r_sync [SYNC_STAGES];
  logic [CW-1:0]        r_cnt  [IN_WIDTH];
  logic [IN_WIDTH-1:0]  r_deb;
  logic [IN_WIDTH-1:0]  r_mask;
  logic [IN_WIDTH-1:0]  r_edge;
  logic [OUT_WIDTH-1:0] r_out;

  logic [IN_WIDTH-1:0]  w_s;
  logic [IN_WIDTH-1:0]  w_hit;
  logic [IN_WIDTH-1:0]  w_set;
  logic [IN_WIDTH-1:0]  w_clr;
  logic [31:0]          w_rd;
  logic                 w_wr_out;
  logic                 w_wr_set;
  logic                 w_wr_clr;
  logic                 w_wr_mask;
  logic                 w_wr_edge;
  logic                 w_unused;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_wr_out  = write && (address == 3'd1);
  assign w_wr_set  = write && (address == 3'd2);
  assign w_wr_clr  = write && (address == 3'd3);
  assign w_wr_mask = write && (address == 3'd4);
  assign w_wr_edge = write && (address == 3'd5);
  assign w_unused  = ^writedata;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < IN_WIDTH; i++)
      w_hit[i] = (w_s[i] != r_deb[i]) && (r_cnt[i] == LAST);
  end

  always_comb begin
    w_set = '0;
    unique case (1'b1)
      (EDGE_TYPE == 0): w_set = w_hit & w_s;
      (EDGE_TYPE == 1): w_set = w_hit & ~w_s;
      default:          w_set = w_hit;
    endcase
  end

  assign w_clr = w_wr_edge ? writedata[IN_WIDTH-1:0] : '0;

  always_comb begin
    w_rd = '0;
    case (address)
      3'd0:    w_rd[IN_WIDTH-1:0]  = r_deb;
      3'd1:    w_rd[OUT_WIDTH-1:0] = r_out;
      3'd4:    w_rd[IN_WIDTH-1:0]  = r_mask;
      3'd5:    w_rd[IN_WIDTH-1:0]  = r_edge;
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  // Counter only advances while s disagrees with d, so it cannot wrap.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < IN_WIDTH; i++) r_cnt[i] <= '0;
      r_deb <= '0;
    end else begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if ((w_s[i] == r_deb[i]) || w_hit[i])
          r_cnt[i] <= '0;
        else
          r_cnt[i] <= r_cnt[i] + CW'(1);
      end
      r_deb <= r_deb ^ w_hit;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_edge   <= '0;
      r_mask   <= '0;
      r_out    <= RESET_OUT;
      readdata <= '0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_set;
      if (w_wr_mask) r_mask <= writedata[IN_WIDTH-1:0];
      if (w_wr_out)  r_out  <= writedata[OUT_WIDTH-1:0];
      if (w_wr_set)  r_out  <= r_out | writedata[OUT_WIDTH-1:0];
      if (w_wr_clr)  r_out  <= r_out & ~writedata[OUT_WIDTH-1:0];
      if (read)      readdata <= w_rd;
    end
  end

  assign out_port = r_out;
  assign irq      = |(r_edge & r_mask);

endmodule

// File: tb/tb_pio_debounce_irq.sv
// Directed bench for pio_debounce_irq: register table plus
// hand-timed debounce, edge-collision and reset sequences.
module tb_pio_debounce_irq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  in_port = '0;
  logic [7:0]  out_port;

  int n_chk = 0;
  int n_err = 0;

  pio_debounce_irq #(
    .IN_WIDTH(8), .OUT_WIDTH(8), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .RESET_OUT(8'h5A)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq),
    .in_port(in_port), .out_port(out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[16];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(logic [2:0] a, logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic bus_rd(logic [2:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
    d = readdata;
  endtask

  logic [31:0] rd;

  initial begin
    vt[0]  = '{0, 3'd1, 32'h0,        32'h0};
    vt[1]  = '{0, 3'd2, 32'h0F,       32'h0};
    vt[2]  = '{2, 3'd0, 32'h0,        32'h0F};
    vt[3]  = '{0, 3'd3, 32'h05,       32'h0};
    vt[4]  = '{2, 3'd0, 32'h0,        32'h0A};
    vt[5]  = '{1, 3'd1, 32'h0,        32'h0A};
    vt[6]  = '{0, 3'd1, 32'hFFFFFFFF, 32'h0};
    vt[7]  = '{1, 3'd1, 32'h0,        32'hFF};
    vt[8]  = '{2, 3'd0, 32'h0,        32'hFF};
    vt[9]  = '{0, 3'd4, 32'hFFFFFFFF, 32'h0};
    vt[10] = '{1, 3'd4, 32'h0,        32'hFF};
    vt[11] = '{1, 3'd6, 32'h0,        32'h0};
    vt[12] = '{0, 3'd0, 32'h123,      32'h0};
    vt[13] = '{1, 3'd0, 32'h0,        32'h0};
    vt[14] = '{1, 3'd2, 32'h0,        32'h0};
    vt[15] = '{0, 3'd4, 32'h0,        32'h0};

    // reset state
    tick(2);
    check("rst_out_port", 32'(out_port), 32'h5A);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_readdata", readdata, 32'h0);
    rst_n = 1'b1;
    tick();
    bus_rd(3'd0, rd); check("rst_data_in", rd, 32'h0);
    bus_rd(3'd4, rd); check("rst_mask", rd, 32'h0);
    bus_rd(3'd5, rd); check("rst_edge", rd, 32'h0);

    for (int i = 0; i < 16; i++) begin
      case (vt[i].op)
        0: bus_wr(vt[i].addr, vt[i].wd);
        1: begin
          bus_rd(vt[i].addr, rd);
          check($sformatf("vec%0d_read", i), rd, vt[i].exp);
        end
        default: check($sformatf("vec%0d_out", i), 32'(out_port), vt[i].exp);
      endcase
    end

    // glitch: 3 cycles high is one short of acceptance
    in_port = 8'h01;
    tick(3);
    in_port = 8'h00;
    tick(6);
    bus_rd(3'd0, rd); check("glitch_data_in", rd, 32'h0);
    bus_rd(3'd5, rd); check("glitch_edge", rd, 32'h0);
    check("glitch_irq", 32'(irq), 32'h0);

    // press: accepted on the 6th edge
    bus_wr(3'd4, 32'h01);
    in_port = 8'h01;
    tick(5);
    check("press_irq_early", 32'(irq), 32'h0);
    tick();
    check("press_irq", 32'(irq), 32'h1);
    bus_rd(3'd0, rd); check("press_data_in", rd, 32'h01);
    bus_rd(3'd5, rd); check("press_edge", rd, 32'h01);
    bus_wr(3'd5, 32'h01);
    check("press_irq_clr", 32'(irq), 32'h0);

    // collision: W1C of bit 1 on the edge it falls
    in_port = 8'h03;
    tick(8);
    bus_wr(3'd5, 32'hFF);
    bus_rd(3'd5, rd); check("coll_edge_clr", rd, 32'h0);
    in_port = 8'h01;
    tick(5);
    bus_wr(3'd5, 32'h02);
    bus_rd(3'd5, rd); check("coll_edge_set_wins", rd, 32'h02);
    bus_rd(3'd0, rd); check("coll_data_in", rd, 32'h01);
    check("coll_irq_masked", 32'(irq), 32'h0);

    // reset mid-debounce after 2 counted cycles on bit 2
    in_port = 8'h05;
    tick(4);
    rst_n = 1'b0;
    tick();
    check("mid_rst_out", 32'(out_port), 32'h5A);
    check("mid_rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    bus_rd(3'd0, rd); check("mid_data_in", rd, 32'h0);
    bus_wr(3'd4, 32'hFF);
    tick(3);
    check("mid_irq_early", 32'(irq), 32'h0);
    tick();
    check("mid_irq", 32'(irq), 32'h1);
    bus_rd(3'd0, rd); check("mid_data_in2", rd, 32'h05);
    bus_rd(3'd5, rd); check("mid_edge", rd, 32'h05);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
